mips32_mem_arbiter: RTL and testbench

//  Arbitrates the single-ported MIPS32 memory (Mem) between the IF stage
//  (instruction fetch, read-only) and the MEM stage (LW/SW data access).

---
 rtl/mips32_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mips32_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares the single-ported MIPS32 memory between the IF
// (fetch) and MEM (LW/SW) stages, serialising accesses of fixed latency.
// Optional feature macro: MIPS32_ARB_RR_EN (round-robin priority).
module mips32_mem_arbiter #(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mips32_mem_arbiter: MEM_LAT must be >= 1");
  end

  localparam int CW = (MEM_LAT >= 1) ? $clog2(MEM_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sel_dm;
  logic          any_req;
  logic          win_dm;

  assign any_req = if_req | dm_req;
  assign busy    = (state != IDLE);

`ifdef MIPS32_ARB_RR_EN
  // prio_if set means IF wins the next contention; DM wins after reset.
  logic prio_if;

  assign win_dm = dm_req & (~if_req | ~prio_if);

  // Hand priority to whichever requester did not win the last grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_if <= 1'b0;
    end else if (state == IDLE && any_req) begin
      prio_if <= win_dm;
    end
  end
`else
  assign win_dm = dm_req;
`endif

  // Access sequencer: grant, strobe memory, count latency, return data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_dm    <= 1'b0;
      if_gnt    <= 1'b0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_gnt    <= 1'b0;
      dm_ack    <= 1'b0;
      dm_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt <= 1'b0;
      dm_gnt <= 1'b0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      mem_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            sel_dm <= win_dm;
            mem_en <= 1'b1;
            cnt    <= CW'(MEM_LAT - 1);
            state  <= ACCESS;
            if (win_dm) begin
              dm_gnt    <= 1'b1;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              if_gnt   <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= if_addr;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state <= DONE;
            if (sel_dm) begin
              dm_ack <= 1'b1;
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter: directed checks of the memory arbiter with
// MEM_LAT=2 (dut a) and MEM_LAT=1 (dut b) against exact-latency memory models.
module tb_mips32_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        a_if_req, a_if_gnt, a_if_ack;
  logic [9:0]  a_if_addr;
  logic [31:0] a_if_rdata;
  logic        a_dm_req, a_dm_we, a_dm_gnt, a_dm_ack;
  logic [9:0]  a_dm_addr;
  logic [31:0] a_dm_wdata, a_dm_rdata;
  logic        a_mem_en, a_mem_we, a_busy;
  logic [9:0]  a_mem_addr;
  logic [31:0] a_mem_wdata, a_mem_rdata;

  logic        b_if_req, b_if_gnt, b_if_ack;
  logic [9:0]  b_if_addr;
  logic [31:0] b_if_rdata;
  logic        b_dm_req, b_dm_we, b_dm_gnt, b_dm_ack;
  logic [9:0]  b_dm_addr;
  logic [31:0] b_dm_wdata, b_dm_rdata;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [9:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;

  mips32_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(2)) u_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_ack(a_if_ack), .if_rdata(a_if_rdata),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr),
    .dm_wdata(a_dm_wdata), .dm_gnt(a_dm_gnt), .dm_ack(a_dm_ack),
    .dm_rdata(a_dm_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mips32_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(1)) u_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr),
    .dm_wdata(b_dm_wdata), .dm_gnt(b_dm_gnt), .dm_ack(b_dm_ack),
    .dm_rdata(b_dm_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory models: read data is valid only in the one cycle the arbiter
  // must capture it, so a wrong latency count returns the poison word.
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  int          age_a;

  always @(posedge clk) begin
    if (rst) age_a <= 0;
    else if (a_mem_en) age_a <= 1;
    else if (age_a != 0 && age_a < 8) age_a <= age_a + 1;
    if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
    if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
  end

  assign a_mem_rdata = (age_a == 1) ? mem_a[a_mem_addr] : 32'hDEADBEEF;
  assign b_mem_rdata = b_mem_en ? mem_b[b_mem_addr] : 32'hDEADBEEF;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [31:0] fetch_exp [0:3];
  logic        exp_dm;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[0]   = 32'h28010078;
    mem_a[2]   = 32'h20220000;
    mem_a[120] = 32'd85;
    fetch_exp[0] = 32'h28010078;
    fetch_exp[1] = 32'h20220000;
    fetch_exp[2] = 32'h11111111;
    fetch_exp[3] = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) mem_b[i] = fetch_exp[i];

    rst = 1'b1;
    a_if_req = 0; a_if_addr = 0;
    a_dm_req = 0; a_dm_we = 0; a_dm_addr = 0; a_dm_wdata = 0;
    b_if_req = 0; b_if_addr = 0;
    b_dm_req = 0; b_dm_we = 0; b_dm_addr = 0; b_dm_wdata = 0;
    repeat (3) step();

    chk("rst_busy", a_busy, 0);
    chk("rst_mem_en", a_mem_en, 0);
    chk("rst_if_rdata", a_if_rdata, 0);
    chk("rst_dm_rdata", a_dm_rdata, 0);
    chk("rst_gnt", {a_if_gnt, a_dm_gnt}, 0);
    chk("rst_ack", {a_if_ack, a_dm_ack}, 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    rst = 1'b0;
    step();

    // single fetch, latency
    a_if_req = 1; a_if_addr = 0;
    step();
    chk("t1_if_gnt", a_if_gnt, 1);
    chk("t1_mem_en", a_mem_en, 1);
    chk("t1_mem_we", a_mem_we, 0);
    chk("t1_mem_addr", a_mem_addr, 0);
    step();
    chk("t1_gnt_pulse", a_if_gnt, 0);
    chk("t1_en_pulse", a_mem_en, 0);
    chk("t1_busy", a_busy, 1);
    chk("t1_no_early_ack", a_if_ack, 0);
    step();
    chk("t1_if_ack", a_if_ack, 1);
    chk("t1_if_rdata", a_if_rdata, 32'h28010078);
    a_if_req = 0;
    step();
    chk("t1_idle", a_busy, 0);
    chk("t1_ack_pulse", a_if_ack, 0);

    // simultaneous requests: DM first
    a_if_req = 1; a_if_addr = 2;
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 120;
    step();
    chk("t2_dm_gnt", a_dm_gnt, 1);
    chk("t2_if_wait", a_if_gnt, 0);
    chk("t2_mem_addr", a_mem_addr, 120);
    step(); step();
    chk("t2_dm_ack", a_dm_ack, 1);
    chk("t2_dm_rdata", a_dm_rdata, 85);
    chk("t2_if_no_ack", a_if_ack, 0);
    a_dm_req = 0;
    step(); step();
    chk("t2_if_gnt", a_if_gnt, 1);
    step(); step();
    chk("t2_if_ack", a_if_ack, 1);
    chk("t2_if_rdata", a_if_rdata, 32'h20220000);
    chk("t2_dm_rdata_hold", a_dm_rdata, 85);
    a_if_req = 0;
    step();

    // store then load back
    a_dm_req = 1; a_dm_we = 1; a_dm_addr = 121; a_dm_wdata = 130;
    step();
    chk("t3_st_gnt", a_dm_gnt, 1);
    chk("t3_st_en_we", {a_mem_en, a_mem_we}, 2'b11);
    chk("t3_st_addr", a_mem_addr, 121);
    chk("t3_st_wdata", a_mem_wdata, 130);
    step();
    chk("t3_st_addr_hold", a_mem_addr, 121);
    chk("t3_st_we_hold", a_mem_we, 1);
    step();
    chk("t3_st_ack", a_dm_ack, 1);
    chk("t3_st_rdata_keep", a_dm_rdata, 85);
    a_dm_req = 0;
    step();
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 121;
    step();
    chk("t3_ld_we", a_mem_we, 0);
    step(); step();
    chk("t3_ld_ack", a_dm_ack, 1);
    chk("t3_ld_rdata", a_dm_rdata, 130);
    a_dm_req = 0;
    step();

    // reset in the middle of a load
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 120;
    step();
    chk("t5_mem_en", a_mem_en, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_en", a_mem_en, 0);
    chk("t5_rst_gnt", a_dm_gnt, 0);
    chk("t5_rst_busy", a_busy, 0);
    chk("t5_rst_dm_rdata", a_dm_rdata, 0);
    chk("t5_rst_if_rdata", a_if_rdata, 0);
    step();
    chk("t5_no_ack", a_dm_ack, 0);
    rst = 1'b0;
    step();
    chk("t5_regnt", a_dm_gnt, 1);
    chk("t5_no_ack2", a_dm_ack, 0);
    step(); step();
    chk("t5_ack", a_dm_ack, 1);
    chk("t5_rdata", a_dm_rdata, 85);
    a_dm_req = 0;
    step();

    // both requesters held: 4 grants from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_if_req = 1; a_if_addr = 0;
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 120;
    for (int k = 0; k < 4; k++) begin
`ifdef MIPS32_ARB_RR_EN
      exp_dm = (k % 2 == 0);
`else
      exp_dm = 1'b1;
`endif
      step();
      chk($sformatf("t4_dm_gnt%0d", k), a_dm_gnt, exp_dm);
      chk($sformatf("t4_if_gnt%0d", k), a_if_gnt, !exp_dm);
      step(); step();
      chk($sformatf("t4_acks%0d", k), {a_dm_ack, a_if_ack},
          {exp_dm, !exp_dm});
      step();
    end
    a_if_req = 0; a_dm_req = 0;
    step();
    chk("t4_idle", a_busy, 0);

    // MEM_LAT=1 back-to-back fetches
    b_if_req = 1; b_if_addr = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t6_gnt%0d", k), b_if_gnt, 1);
      step();
      chk($sformatf("t6_ack%0d", k), b_if_ack, 1);
      chk($sformatf("t6_rdata%0d", k), b_if_rdata, fetch_exp[k]);
      if (k == 3) b_if_req = 0;
      else b_if_addr = 10'(k + 1);
      step();
      chk($sformatf("t6_gap%0d", k), b_if_ack, 0);
    end
    step();
    chk("t6_idle", b_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
